// File: rtl/code_mem_arbiter_pkg.sv
// Shared definitions for the code/system memory arbiter.
// Holds the FSM state encodings, the requester IDs, the read byte-enable constant
// and the memory command payload that the arbiter registers onto the oMem* port.
package code_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0] RD_BYTE_EN = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // One memory access as driven onto the shared port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } mem_cmd_t;

endpackage

// File: rtl/code_mem_arb_prio.sv
// D-priority pick with an anti-starvation guard for the instruction requester.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   arb_en        high while the arbiter is idle and may issue a grant
//   ireq, dreq    raw instruction / data requests
//   gnt_valid_c   some request is pending (combinational)
//   gnt_is_d_c    1 = D wins this cycle, 0 = I wins (combinational)
module code_mem_arb_prio
    import code_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic ireq,
    input  logic dreq,
    output logic gnt_valid_c,
    output logic gnt_is_d_c
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] starve_q;
    logic          starved_c;

    // I is forced through once D has won STARVE_LIM times in a row over it.
    assign starved_c   = (starve_q == SW'(STARVE_LIM));
    assign gnt_is_d_c  = dreq && !(starved_c && ireq);
    assign gnt_valid_c = ireq || dreq;

    // Count consecutive D wins while I waits; any I win or idle I clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (arb_en) begin
            if (!ireq || !gnt_is_d_c) begin
                starve_q <= '0;
            end else if (!starved_c) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

endmodule

// File: rtl/code_mem_arbiter.sv
// Shares the single code/system memory port between instruction fetch (I) and
// load/store (D). One access in flight: IDLE -> CMD -> WAIT x READ_LAT -> IDLE for
// reads, IDLE -> CMD -> IDLE for stores. D has priority, I is protected from starvation.
// Ports:
//   iCLK, iRST                      clock, asynchronous active-high reset
//   iIReq/iIAddress                 fetch request; oIGnt, oIValid, oIRdata responses
//   iDReq/iDWe/iDByteEnable/
//   iDAddress/iDWriteData           load/store request; oDGnt, oDValid, oDRdata responses
//   oMemAddress/oMemByteEnable/
//   oMemWriteData/oMemRead/oMemWrite memory command; iMemData memory read data
//   oMisalign                       pulses with a grant whose address[1:0] != 0
//   oIStallCnt/oDStallCnt           request-stall counters
// Build option: define MEMARB_PERF_CNT_EN to implement the stall counters; otherwise
// both counters read as zero.
module code_mem_arbiter
    import code_mem_arbiter_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddress,
    output logic        oIGnt,
    output logic        oIValid,
    output logic [31:0] oIRdata,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic        oDGnt,
    output logic        oDValid,
    output logic [31:0] oDRdata,
    output logic [31:0] oMemAddress,
    output logic [3:0]  oMemByteEnable,
    output logic [31:0] oMemWriteData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData,
    output logic        oMisalign,
    output logic [31:0] oIStallCnt,
    output logic [31:0] oDStallCnt
);

    state_t      state_q, state_d;
    logic [1:0]  wcnt_q, wcnt_d;
    req_id_t     owner_q, owner_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        ignt_d, dgnt_d, ivalid_d, dvalid_d, misalign_d;
    logic        rd_done_c;
    logic [31:0] irdata_q, drdata_q;
    logic        arb_en_c, gnt_valid_c, gnt_is_d_c;

    code_mem_arb_prio #(.STARVE_LIM(STARVE_LIM)) u_prio (
        .clk         (iCLK),
        .rst         (iRST),
        .arb_en      (arb_en_c),
        .ireq        (iIReq),
        .dreq        (iDReq),
        .gnt_valid_c (gnt_valid_c),
        .gnt_is_d_c  (gnt_is_d_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        cmd_d.rd   = 1'b0;
        cmd_d.wr   = 1'b0;
        ignt_d     = 1'b0;
        dgnt_d     = 1'b0;
        misalign_d = 1'b0;
        rd_done_c  = 1'b0;
        arb_en_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                arb_en_c = 1'b1;
                if (gnt_valid_c) begin
                    state_d = ST_CMD;
                    if (gnt_is_d_c) begin
                        owner_d     = REQ_D;
                        dgnt_d      = 1'b1;
                        misalign_d  = |iDAddress[1:0];
                        cmd_d.addr  = {iDAddress[31:2], 2'b00};
                        cmd_d.be    = iDWe ? iDByteEnable : RD_BYTE_EN;
                        cmd_d.wdata = iDWe ? iDWriteData : '0;
                        cmd_d.rd    = !iDWe;
                        cmd_d.wr    = iDWe;
                    end else begin
                        owner_d     = REQ_I;
                        ignt_d      = 1'b1;
                        misalign_d  = |iIAddress[1:0];
                        cmd_d.addr  = {iIAddress[31:2], 2'b00};
                        cmd_d.be    = RD_BYTE_EN;
                        cmd_d.wdata = '0;
                        cmd_d.rd    = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (cmd_q.wr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_WAIT;
                    wcnt_d    = 2'(READ_LAT - 1);
                    rd_done_c = (READ_LAT == 1);
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d    = wcnt_q - 2'd1;
                    rd_done_c = (wcnt_q == 2'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Valid is registered so it is high in the last WAIT cycle, when iMemData is live.
        ivalid_d = rd_done_c && (owner_q == REQ_I);
        dvalid_d = rd_done_c && (owner_q == REQ_D);
    end

    // State and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 2'd0;
            owner_q   <= REQ_I;
            cmd_q     <= '0;
            oIGnt     <= 1'b0;
            oDGnt     <= 1'b0;
            oIValid   <= 1'b0;
            oDValid   <= 1'b0;
            oMisalign <= 1'b0;
            irdata_q  <= '0;
            drdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            oIGnt     <= ignt_d;
            oDGnt     <= dgnt_d;
            oIValid   <= ivalid_d;
            oDValid   <= dvalid_d;
            oMisalign <= misalign_d;
            if (oIValid) irdata_q <= iMemData;
            if (oDValid) drdata_q <= iMemData;
        end
    end

    assign oMemAddress    = cmd_q.addr;
    assign oMemByteEnable = cmd_q.be;
    assign oMemWriteData  = cmd_q.wdata;
    assign oMemRead       = cmd_q.rd;
    assign oMemWrite      = cmd_q.wr;

    // Read data passes straight through in its valid cycle; the flop holds it afterwards.
    assign oIRdata = oIValid ? iMemData : irdata_q;
    assign oDRdata = oDValid ? iMemData : drdata_q;

`ifdef MEMARB_PERF_CNT_EN
    logic [31:0] istall_q, dstall_q;

    // Saturating counts of cycles a request waits without a grant.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            if (iIReq && !oIGnt && (istall_q != 32'hFFFF_FFFF)) istall_q <= istall_q + 32'd1;
            if (iDReq && !oDGnt && (dstall_q != 32'hFFFF_FFFF)) dstall_q <= dstall_q + 32'd1;
        end
    end

    assign oIStallCnt = istall_q;
    assign oDStallCnt = dstall_q;
`else
    assign oIStallCnt = 32'h0;
    assign oDStallCnt = 32'h0;
`endif

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Directed bench for code_mem_arbiter (READ_LAT=1, STARVE_LIM=4).
module tb_code_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iIReq;
    logic [31:0] iIAddress;
    logic        oIGnt, oIValid;
    logic [31:0] oIRdata;
    logic        iDReq, iDWe;
    logic [3:0]  iDByteEnable;
    logic [31:0] iDAddress, iDWriteData;
    logic        oDGnt, oDValid;
    logic [31:0] oDRdata;
    logic [31:0] oMemAddress;
    logic [3:0]  oMemByteEnable;
    logic [31:0] oMemWriteData;
    logic        oMemRead, oMemWrite;
    logic [31:0] iMemData = 32'h0BAD_0BAD;
    logic        oMisalign;
    logic [31:0] oIStallCnt, oDStallCnt;

    int total = 0;
    int bad   = 0;

    code_mem_arbiter #(.READ_LAT(1), .STARVE_LIM(4)) dut (
        .iCLK(clk), .iRST(rst),
        .iIReq(iIReq), .iIAddress(iIAddress), .oIGnt(oIGnt), .oIValid(oIValid), .oIRdata(oIRdata),
        .iDReq(iDReq), .iDWe(iDWe), .iDByteEnable(iDByteEnable), .iDAddress(iDAddress),
        .iDWriteData(iDWriteData), .oDGnt(oDGnt), .oDValid(oDValid), .oDRdata(oDRdata),
        .oMemAddress(oMemAddress), .oMemByteEnable(oMemByteEnable), .oMemWriteData(oMemWriteData),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .iMemData(iMemData), .oMisalign(oMisalign),
        .oIStallCnt(oIStallCnt), .oDStallCnt(oDStallCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous RAM, one cycle latency; garbage when not reading.
    always @(posedge clk) iMemData <= oMemRead ? memword(oMemAddress) : 32'h0BAD_0BAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iIReq = 1'b0; iIAddress = '0; iDReq = 1'b0; iDWe = 1'b0;
        iDByteEnable = '0; iDAddress = '0; iDWriteData = '0;
        step(); step();
        total++; if ({oIGnt, oIValid, oIRdata, oDGnt, oDValid, oDRdata, oMemAddress, oMemByteEnable,
                      oMemWriteData, oMemRead, oMemWrite, oMisalign, oIStallCnt, oDStallCnt} !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero, memaddr=%h rd=%b", oMemAddress, oMemRead);
        end
        @(negedge clk) rst = 1'b0;
        step();
    endtask

    task automatic test_ifetch();
        iIReq = 1'b1; iIAddress = 32'h40;
        step();
        total++; if (oIGnt !== 1'b1) begin bad++; $display("FAIL t1_ignt got=%b exp=1", oIGnt); end
        total++; if ({oMemRead, oMemWrite} !== 2'b10) begin bad++; $display("FAIL t1_strobes got=%b exp=10", {oMemRead, oMemWrite}); end
        total++; if (oMemAddress !== 32'h40) begin bad++; $display("FAIL t1_addr got=%h exp=00000040", oMemAddress); end
        total++; if (oMemByteEnable !== 4'hF) begin bad++; $display("FAIL t1_be got=%h exp=f", oMemByteEnable); end
        iIReq = 1'b0;
        step();
        total++; if (oIValid !== 1'b1) begin bad++; $display("FAIL t1_ivalid got=%b exp=1", oIValid); end
        total++; if (oIRdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_idata got=%h exp=deadbeef", oIRdata); end
        total++; if (oMemRead !== 1'b0) begin bad++; $display("FAIL t1_read_one_cycle got=%b exp=0", oMemRead); end
        step();
        total++; if (oIValid !== 1'b0) begin bad++; $display("FAIL t1_ivalid_pulse got=%b exp=0", oIValid); end
        total++; if (oIRdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_idata_hold got=%h exp=deadbeef", oIRdata); end
    endtask

    task automatic test_dpriority();
        iIReq = 1'b1; iIAddress = 32'h80;
        iDReq = 1'b1; iDWe = 1'b0; iDAddress = 32'h100;
        step();
        total++; if ({oDGnt, oIGnt} !== 2'b10) begin bad++; $display("FAIL t2_d_first got dgnt,ignt=%b exp=10", {oDGnt, oIGnt}); end
        total++; if (oMemAddress !== 32'h100) begin bad++; $display("FAIL t2_daddr got=%h exp=00000100", oMemAddress); end
        iDReq = 1'b0;
        step();
        total++; if ({oDValid, oIValid} !== 2'b10) begin bad++; $display("FAIL t2_dvalid got=%b exp=10", {oDValid, oIValid}); end
        total++; if (oDRdata !== memword(32'h100)) begin bad++; $display("FAIL t2_ddata got=%h exp=%h", oDRdata, memword(32'h100)); end
        step();
        total++; if (oIGnt !== 1'b0) begin bad++; $display("FAIL t2_no_cmd_in_idle got=%b exp=0", oIGnt); end
        step();
        total++; if (oIGnt !== 1'b1) begin bad++; $display("FAIL t2_i_second got=%b exp=1", oIGnt); end
        total++; if (oMemAddress !== 32'h80) begin bad++; $display("FAIL t2_iaddr got=%h exp=00000080", oMemAddress); end
        iIReq = 1'b0;
        step();
        total++; if (oIRdata !== memword(32'h80)) begin bad++; $display("FAIL t2_idata got=%h exp=%h", oIRdata, memword(32'h80)); end
        total++; if (oDRdata !== memword(32'h100)) begin bad++; $display("FAIL t2_ddata_hold got=%h exp=%h", oDRdata, memword(32'h100)); end
        step();
    endtask

    task automatic test_starvation();
        iIReq = 1'b1; iIAddress = 32'h200;
        iDReq = 1'b1; iDWe = 1'b0; iDAddress = 32'h300;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = 0;
            step();
            while (!(oIGnt || oDGnt) && w < 8) begin step(); w++; end
            if (k < 4) begin
                total++; if ({oDGnt, oIGnt} !== 2'b10) begin bad++; $display("FAIL t3_grant%0d got dgnt,ignt=%b exp=10", k, {oDGnt, oIGnt}); end
            end else begin
                total++; if ({oDGnt, oIGnt} !== 2'b01) begin bad++; $display("FAIL t3_grant%0d got dgnt,ignt=%b exp=01", k, {oDGnt, oIGnt}); end
            end
        end
        iIReq = 1'b0; iDReq = 1'b0;
        step();
        total++; if (oIRdata !== memword(32'h200)) begin bad++; $display("FAIL t3_idata got=%h exp=%h", oIRdata, memword(32'h200)); end
        step();
    endtask

    task automatic test_store_back_to_back();
        iDReq = 1'b1; iDWe = 1'b1; iDByteEnable = 4'b0011; iDAddress = 32'h2002; iDWriteData = 32'h1234;
        step();
        total++; if ({oDGnt, oMemWrite, oMemRead} !== 3'b110) begin bad++; $display("FAIL t4_gnt_wr_rd got=%b exp=110", {oDGnt, oMemWrite, oMemRead}); end
        total++; if (oMemAddress !== 32'h2000) begin bad++; $display("FAIL t4_addr got=%h exp=00002000", oMemAddress); end
        total++; if (oMemByteEnable !== 4'b0011) begin bad++; $display("FAIL t4_be got=%b exp=0011", oMemByteEnable); end
        total++; if (oMemWriteData !== 32'h1234) begin bad++; $display("FAIL t4_wdata got=%h exp=00001234", oMemWriteData); end
        total++; if (oMisalign !== 1'b1) begin bad++; $display("FAIL t4_misalign got=%b exp=1", oMisalign); end
        iDReq = 1'b0; iDWe = 1'b0;
        iIReq = 1'b1; iIAddress = 32'h44;
        step();
        total++; if ({oMemWrite, oDGnt, oMisalign, oDValid, oIGnt} !== 5'b0) begin bad++; $display("FAIL t4_after_store got=%b exp=00000", {oMemWrite, oDGnt, oMisalign, oDValid, oIGnt}); end
        step();
        total++; if ({oIGnt, oMemRead, oMisalign} !== 3'b110) begin bad++; $display("FAIL t4_b2b_ignt got=%b exp=110", {oIGnt, oMemRead, oMisalign}); end
        total++; if (oMemByteEnable !== 4'hF) begin bad++; $display("FAIL t4_b2b_be got=%h exp=f", oMemByteEnable); end
        iIReq = 1'b0;
        step();
        total++; if (oIRdata !== memword(32'h44)) begin bad++; $display("FAIL t4_b2b_data got=%h exp=%h", oIRdata, memword(32'h44)); end
        step();
    endtask

    task automatic test_reset_mid_read();
        iIReq = 1'b1; iIAddress = 32'h48;
        step();
        total++; if (oIGnt !== 1'b1) begin bad++; $display("FAIL t5_ignt got=%b exp=1", oIGnt); end
        iIReq = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({oIValid, oIRdata, oMemRead, oMemAddress, oIGnt, oMemByteEnable} !== '0) begin
            bad++; $display("FAIL t5_reset_clears got valid=%b rdata=%h addr=%h", oIValid, oIRdata, oMemAddress);
        end
        @(negedge clk) rst = 1'b0;
        step();
        total++; if ({oIValid, oMemRead} !== 2'b00) begin bad++; $display("FAIL t5_no_late_valid got=%b exp=00", {oIValid, oMemRead}); end
        iIReq = 1'b1; iIAddress = 32'h4C;
        step();
        total++; if (oIGnt !== 1'b1) begin bad++; $display("FAIL t5_regrant got=%b exp=1", oIGnt); end
        iIReq = 1'b0;
        step();
        total++; if (oIRdata !== memword(32'h4C)) begin bad++; $display("FAIL t5_data got=%h exp=%h", oIRdata, memword(32'h4C)); end
        step();
    endtask

    task automatic test_perf_cnt();
        logic [31:0] exp_d, exp_i;
`ifdef MEMARB_PERF_CNT_EN
        exp_d = 32'd3; exp_i = 32'd1;
`else
        exp_d = 32'd0; exp_i = 32'd0;
`endif
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        step();
        iIReq = 1'b1; iIAddress = 32'h50;
        step();
        iIReq = 1'b0;
        iDReq = 1'b1; iDWe = 1'b0; iDAddress = 32'h60;
        step(); step();
        total++; if (oDGnt !== 1'b0) begin bad++; $display("FAIL t6_d_blocked got=%b exp=0", oDGnt); end
        step();
        total++; if (oDGnt !== 1'b1) begin bad++; $display("FAIL t6_dgnt got=%b exp=1", oDGnt); end
        iDReq = 1'b0;
        step(); step();
        total++; if (oDStallCnt !== exp_d) begin bad++; $display("FAIL t6_dstall got=%0d exp=%0d", oDStallCnt, exp_d); end
        total++; if (oIStallCnt !== exp_i) begin bad++; $display("FAIL t6_istall got=%0d exp=%0d", oIStallCnt, exp_i); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ifetch();
        test_dpriority();
        test_starvation();
        test_store_back_to_back();
        test_reset_mid_read();
        test_perf_cnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
